// File: rtl/tdc_pkg.sv
// Shared types and width helpers for the TDC code accumulator.
// Holds the FSM state encoding and the default tap count.
package tdc_pkg;

  localparam int TAPS_DEF = 32;

  typedef enum logic [1:0] {
    IDLE,
    ACCUM,
    HOLD
  } state_t;

  function automatic int cnt_width(input int taps);
    return $clog2(taps + 1);
  endfunction

endpackage

// File: rtl/tdc_code_accumulator_if.sv
// Result port of the TDC accumulator: valid/ready plus mean/min/max.
// The producer drives valid and data; the consumer drives ready.
interface tdc_code_accumulator_if #(
  parameter int CNT_W = 6
);
  logic             result_valid;
  logic             result_ready;
  logic [CNT_W-1:0] result_mean;
  logic [CNT_W-1:0] result_min;
  logic [CNT_W-1:0] result_max;

  modport master (
    output result_valid,
    output result_mean,
    output result_min,
    output result_max,
    input  result_ready
  );

  modport slave (
    input  result_valid,
    input  result_mean,
    input  result_min,
    input  result_max,
    output result_ready
  );
endinterface

// File: rtl/tdc_therm_encoder.sv
// Thermometer code to tap count. Define TDC_BUBBLE_FIX_EN to
// majority-filter single-bit bubbles before the popcount.
module tdc_therm_encoder #(
  parameter int TAPS  = 32,
  parameter int CNT_W = 6
) (
  input  logic [TAPS-1:0]  i_code,
  output logic [CNT_W-1:0] o_count
);

  logic [TAPS-1:0] w_t;

`ifdef TDC_BUBBLE_FIX_EN
  // Ends padded so the first tap sees a 1 below and the last a 0 above
  logic [TAPS+1:0] w_ext;
  assign w_ext = {1'b0, i_code, 1'b1};

  always_comb begin
    w_t = '0;
    for (int i = 0; i < TAPS; i++) begin
      w_t[i] = (w_ext[i]   & w_ext[i+1]) |
               (w_ext[i]   & w_ext[i+2]) |
               (w_ext[i+1] & w_ext[i+2]);
    end
  end
`else
  assign w_t = i_code;
`endif

  always_comb begin
    o_count = '0;
    for (int i = 0; i < TAPS; i++) begin
      o_count = o_count + CNT_W'(w_t[i]);
    end
  end

endmodule

// File: rtl/tdc_code_accumulator.sv
// Burst accumulator for the delay-line TDC: mean/min/max of 2**LOG2_N
// encoded samples. Encoder honours TDC_BUBBLE_FIX_EN.
module tdc_code_accumulator
  import tdc_pkg::*;
#(
  parameter int TAPS   = TAPS_DEF,
  parameter int LOG2_N = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            i_start,
  input  logic            i_sample_valid,
  input  logic [TAPS-1:0] i_therm_code,
  output logic            o_busy,
  output logic [3:0]      o_drop_cnt,
  tdc_code_accumulator_if.master res
);

  localparam int CNT_W = cnt_width(TAPS);
  localparam int ACC_W = CNT_W + LOG2_N;
  localparam logic [LOG2_N:0] N_L = {1'b1, {LOG2_N{1'b0}}};
  localparam logic [CNT_W-1:0] TAPS_L = CNT_W'(TAPS);

  state_t r_state, w_next;

  logic [LOG2_N:0]  r_cnt;
  logic             r_s1_v;
  logic [CNT_W-1:0] r_s1_cnt;
  logic             r_last;
  logic [ACC_W-1:0] r_acc;
  logic [CNT_W-1:0] r_min, r_max, r_mean;
  logic             r_valid;
  logic [3:0]       r_drop;
  logic [CNT_W-1:0] w_enc;

  logic w_clear, w_accept, w_drop, w_finish, w_hs;

  tdc_therm_encoder #(
    .TAPS  (TAPS),
    .CNT_W (CNT_W)
  ) u_enc (
    .i_code  (i_therm_code),
    .o_count (w_enc)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next   = r_state;
    w_clear  = 1'b0;
    w_accept = 1'b0;
    w_drop   = 1'b0;
    w_finish = 1'b0;
    w_hs     = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (i_start) begin
          w_clear = 1'b1;
          w_next  = ACCUM;
        end else if (i_sample_valid) begin
          w_drop = 1'b1;
        end
      end
      ACCUM: begin
        if (i_start) begin
          w_clear = 1'b1;
        end else begin
          if (i_sample_valid && r_cnt < N_L) w_accept = 1'b1;
          else if (i_sample_valid)           w_drop   = 1'b1;
          if (r_last) begin
            w_finish = 1'b1;
            w_next   = HOLD;
          end
        end
      end
      HOLD: begin
        w_drop = i_sample_valid;
        if (r_valid && res.result_ready) begin
          w_hs   = 1'b1;
          w_next = IDLE;
        end
      end
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt    <= '0;
      r_s1_v   <= 1'b0;
      r_s1_cnt <= '0;
      r_last   <= 1'b0;
      r_acc    <= '0;
      r_min    <= TAPS_L;
      r_max    <= '0;
      r_mean   <= '0;
      r_valid  <= 1'b0;
      r_drop   <= '0;
    end else begin
      if (w_clear) begin
        r_cnt  <= '0;
        r_s1_v <= 1'b0;
        r_last <= 1'b0;
        r_acc  <= '0;
        r_min  <= TAPS_L;
        r_max  <= '0;
        r_drop <= '0;
      end else begin
        r_s1_v <= w_accept;
        if (w_accept) begin
          r_s1_cnt <= w_enc;
          r_cnt    <= r_cnt + 1'b1;
        end
        if (r_s1_v) begin
          r_acc <= r_acc + ACC_W'(r_s1_cnt);
          if (r_s1_cnt < r_min) r_min <= r_s1_cnt;
          if (r_s1_cnt > r_max) r_max <= r_s1_cnt;
        end
        // Counter already reads N when the last sample reaches stage 2
        r_last <= r_s1_v && (r_cnt == N_L);
        if (w_drop && r_drop != 4'hF) r_drop <= r_drop + 1'b1;
      end
      if (w_finish) begin
        r_mean  <= r_acc[ACC_W-1:LOG2_N];
        r_valid <= 1'b1;
      end else if (w_hs) begin
        r_valid <= 1'b0;
      end
    end
  end

  assign o_busy           = (r_state == ACCUM);
  assign o_drop_cnt       = r_drop;
  assign res.result_valid = r_valid;
  assign res.result_mean  = r_mean;
  assign res.result_min   = r_min;
  assign res.result_max   = r_max;

endmodule

// File: tb/tb_tdc_code_accumulator.sv
// Directed plus randomized bench for tdc_code_accumulator.
// Reference results come from a queue of accepted sample counts.
module tb_tdc_code_accumulator;

  logic        clk = 1'b0;
  logic        rst;
  logic        i_start;
  logic        i_sv;
  logic [31:0] i_code;
  logic        o_busy;
  logic [3:0]  o_drop;

  tdc_code_accumulator_if #(.CNT_W(6)) res_if ();

  tdc_code_accumulator #(
    .TAPS   (32),
    .LOG2_N (4)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .i_start        (i_start),
    .i_sample_valid (i_sv),
    .i_therm_code   (i_code),
    .o_busy         (o_busy),
    .o_drop_cnt     (o_drop),
    .res            (res_if.master)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  int q[$];

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic int enc(input logic [31:0] c);
    int n;
    int p, nx;
    n = 0;
`ifdef TDC_BUBBLE_FIX_EN
    for (int i = 0; i < 32; i++) begin
      p  = (i == 0)  ? 1 : int'(c[(i+31)%32]);
      nx = (i == 31) ? 0 : int'(c[(i+1)%32]);
      if (p + int'(c[i]) + nx >= 2) n++;
    end
`else
    n = $countones(c);
`endif
    return n;
  endfunction

  task automatic cyc(input bit s, input bit v, input logic [31:0] c);
    i_start = s;
    i_sv    = v;
    i_code  = c;
    @(posedge clk);
    #1;
    i_start = 1'b0;
    i_sv    = 1'b0;
  endtask

  task automatic start_burst(input bit v, input logic [31:0] c);
    cyc(1'b1, v, c);
    q.delete();
  endtask

  task automatic feed(input logic [31:0] c, input bit gap);
    if (gap) cyc(1'b0, 1'b0, 32'h0);
    cyc(1'b0, 1'b1, c);
    q.push_back(enc(c));
  endtask

  task automatic check_result(input string tag);
    int sum, mn, mx;
    sum = 0;
    mn  = 32;
    mx  = 0;
    foreach (q[i]) begin
      sum += q[i];
      if (q[i] < mn) mn = q[i];
      if (q[i] > mx) mx = q[i];
    end
    check({tag, "_mean"}, 32'(res_if.result_mean), 32'(sum / 16));
    check({tag, "_min"},  32'(res_if.result_min),  32'(mn));
    check({tag, "_max"},  32'(res_if.result_max),  32'(mx));
  endtask

  // Called just after the edge that captured the last sample
  task automatic finish(input string tag);
    check({tag, "_lat0"}, 32'(res_if.result_valid), 32'd0);
    cyc(1'b0, 1'b0, 32'h0);
    check({tag, "_lat1"}, 32'(res_if.result_valid), 32'd0);
    check({tag, "_busy1"}, 32'(o_busy), 32'd1);
    cyc(1'b0, 1'b0, 32'h0);
    check({tag, "_lat2"}, 32'(res_if.result_valid), 32'd1);
    check({tag, "_busy2"}, 32'(o_busy), 32'd0);
    check_result(tag);
  endtask

  task automatic accept(input string tag);
    res_if.result_ready = 1'b1;
    @(posedge clk);
    #1;
    res_if.result_ready = 1'b0;
    check({tag, "_acc_valid"}, 32'(res_if.result_valid), 32'd0);
    check({tag, "_acc_busy"}, 32'(o_busy), 32'd0);
  endtask

  initial begin
    rst = 1'b1;
    i_start = 1'b0;
    i_sv = 1'b0;
    i_code = '0;
    res_if.result_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy",  32'(o_busy), 32'd0);
    check("rst_valid", 32'(res_if.result_valid), 32'd0);
    check("rst_drop",  32'(o_drop), 32'd0);
    check("rst_mean",  32'(res_if.result_mean), 32'd0);
    check("rst_min",   32'(res_if.result_min), 32'd32);
    check("rst_max",   32'(res_if.result_max), 32'd0);
    rst = 1'b0;
    cyc(1'b0, 1'b0, 32'h0);

    // Basic burst
    start_burst(1'b0, 32'h0);
    check("basic_busy", 32'(o_busy), 32'd1);
    for (int i = 0; i < 16; i++) feed(32'h0000_FFFF, 1'b0);
    finish("basic");
    check("basic_mean_k", 32'(res_if.result_mean), 32'd16);
    accept("basic");

    // Mixed burst, then back-pressure
    start_burst(1'b0, 32'h0);
    for (int i = 0; i < 8; i++) feed(32'h0000_00FF, 1'b0);
    for (int i = 0; i < 8; i++) feed(32'hFFFF_FFFF, 1'b0);
    finish("mixed");
    check("mixed_mean_k", 32'(res_if.result_mean), 32'd20);
    check("mixed_min_k",  32'(res_if.result_min),  32'd8);
    check("mixed_max_k",  32'(res_if.result_max),  32'd32);
    for (int i = 0; i < 10; i++) begin
      cyc(1'b0, 1'b0, 32'h0);
      check("hold_valid", 32'(res_if.result_valid), 32'd1);
      check("hold_mean",  32'(res_if.result_mean), 32'd20);
      check("hold_min",   32'(res_if.result_min), 32'd8);
      check("hold_max",   32'(res_if.result_max), 32'd32);
    end
    accept("mixed");

    // Bubble, then drops in HOLD and IDLE
    start_burst(1'b0, 32'h0);
    for (int i = 0; i < 16; i++) feed(32'h0000_FEFF, 1'b0);
    finish("bubble");
`ifdef TDC_BUBBLE_FIX_EN
    check("bubble_k", 32'(res_if.result_mean), 32'd16);
`else
    check("bubble_k", 32'(res_if.result_mean), 32'd15);
`endif
    cyc(1'b1, 1'b1, 32'hFFFF_FFFF);
    cyc(1'b0, 1'b1, 32'hFFFF_FFFF);
    check("hold_start_ign", 32'(res_if.result_valid), 32'd1);
    check("hold_max_keep",  32'(res_if.result_max), 32'(enc(32'h0000_FEFF)));
    accept("bubble");
    for (int i = 0; i < 3; i++) cyc(1'b0, 1'b1, 32'h1);
    check("drop5", 32'(o_drop), 32'd5);

    // 17th sample is ignored and counted as a drop
    start_burst(1'b0, 32'h0);
    check("drop_clr", 32'(o_drop), 32'd0);
    for (int i = 0; i < 16; i++) feed(32'h0000_000F, 1'b0);
    cyc(1'b0, 1'b1, 32'hFFFF_FFFF);
    check("s17_lat1", 32'(res_if.result_valid), 32'd0);
    cyc(1'b0, 1'b0, 32'h0);
    check("s17_lat2", 32'(res_if.result_valid), 32'd1);
    check_result("s17");
    check("s17_max_k", 32'(res_if.result_max), 32'd4);
    check("s17_drop", 32'(o_drop), 32'd1);
    for (int i = 0; i < 20; i++) cyc(1'b0, 1'b1, 32'h0);
    check("drop_sat", 32'(o_drop), 32'd15);
    accept("s17");

    // Restart after 7 samples discards them, including the in-flight one
    start_burst(1'b0, 32'h0);
    for (int i = 0; i < 7; i++) feed(32'hFFFF_FFFF, 1'b0);
    start_burst(1'b0, 32'h0);
    for (int i = 0; i < 15; i++) feed(32'h0000_0003, 1'b0);
    repeat (3) cyc(1'b0, 1'b0, 32'h0);
    check("rs_notdone", 32'(res_if.result_valid), 32'd0);
    check("rs_busy", 32'(o_busy), 32'd1);
    feed(32'h0000_0003, 1'b0);
    finish("restart");
    check("restart_max_k", 32'(res_if.result_max), 32'd2);
    accept("restart");

    // Asynchronous reset mid-burst
    start_burst(1'b0, 32'h0);
    for (int i = 0; i < 5; i++) feed(32'h0000_0001, 1'b0);
    rst = 1'b1;
    #2;
    check("arst_busy",  32'(o_busy), 32'd0);
    check("arst_valid", 32'(res_if.result_valid), 32'd0);
    check("arst_min",   32'(res_if.result_min), 32'd32);
    check("arst_max",   32'(res_if.result_max), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Gappy input; start coincident with a sample never counts it
    start_burst(1'b1, 32'hFFFF_FFFF);
    for (int i = 0; i < 3; i++) feed(32'h0000_0001, 1'b1);
    start_burst(1'b1, 32'hFFFF_FFFF);
    for (int i = 0; i < 16; i++) feed(32'h0000_0001, 1'b1);
    finish("gappy");
    check("gappy_mean_k", 32'(res_if.result_mean), 32'd1);
    check("gappy_max_k",  32'(res_if.result_max), 32'd1);
    accept("gappy");

    // Randomized bursts
    for (int r = 0; r < 4; r++) begin
      start_burst(1'b0, 32'h0);
      for (int i = 0; i < 16; i++)
        feed($urandom, 1'($urandom_range(0, 1)));
      finish("rnd");
      repeat ($urandom_range(0, 3)) begin
        cyc(1'b0, 1'b0, 32'h0);
        check_result("rnd_hold");
      end
      accept("rnd");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
